// File: rtl/aclk_pkg.sv
// Shared alarm-clock types, digit limits and BCD time validation.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package aclk_pkg;

  localparam logic [3:0] HR_MS_MAX      = 4'd2;
  localparam logic [3:0] HR_LS_MAX_AT_2 = 4'd3;
  localparam logic [3:0] MIN_MS_MAX     = 4'd5;
  localparam logic [3:0] DIGIT_MAX      = 4'd9;

  // HH:MM as four BCD digits, most significant digit first.
  typedef struct packed {
    logic [3:0] ms_hr;
    logic [3:0] ls_hr;
    logic [3:0] ms_min;
    logic [3:0] ls_min;
  } bcd_time_t;

  // True when the value is a legal 24-hour time 00:00..23:59.
  function automatic logic bcd_time_valid(input bcd_time_t t);
    logic ok;
    ok = (t.ms_hr <= HR_MS_MAX) &&
         (t.ls_hr <= DIGIT_MAX) &&
         !((t.ms_hr == HR_MS_MAX) && (t.ls_hr > HR_LS_MAX_AT_2)) &&
         (t.ms_min <= MIN_MS_MAX) &&
         (t.ls_min <= DIGIT_MAX);
    return ok;
  endfunction

endpackage

// File: rtl/aclk_bcd_minute_inc.sv
// Next-minute BCD cascade on an HH:MM value, wrapping 23:59 to 00:00.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module aclk_bcd_minute_inc
  import aclk_pkg::*;
(
  input  bcd_time_t cur_i,
  output bcd_time_t nxt_o
);

  // Ripple carries from ls_min up through the hour digits.
  always_comb begin
    nxt_o = cur_i;
    if (cur_i.ls_min == DIGIT_MAX) begin
      nxt_o.ls_min = 4'd0;
      if (cur_i.ms_min == MIN_MS_MAX) begin
        nxt_o.ms_min = 4'd0;
        if ((cur_i.ms_hr == HR_MS_MAX) && (cur_i.ls_hr == HR_LS_MAX_AT_2)) begin
          nxt_o.ms_hr = 4'd0;
          nxt_o.ls_hr = 4'd0;
        end else if (cur_i.ls_hr == DIGIT_MAX) begin
          nxt_o.ls_hr = 4'd0;
          nxt_o.ms_hr = cur_i.ms_hr + 4'd1;
        end else begin
          nxt_o.ls_hr = cur_i.ls_hr + 4'd1;
        end
      end else begin
        nxt_o.ms_min = cur_i.ms_min + 4'd1;
      end
    end else begin
      nxt_o.ls_min = cur_i.ls_min + 4'd1;
    end
  end

endmodule

// File: rtl/aclk_time_keeper.sv
// Current-time and alarm-time registers with seconds counter and keypad loads.
// Latency: loads, minute rollover and load_err all appear 1 cycle after the sampling edge.
// Backpressure: none; every strobe and command is consumed in the cycle it is presented.
module aclk_time_keeper
  import aclk_pkg::*;
#(
  parameter int SEC_PER_MIN = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       one_second,
  input  logic       load_new_c,
  input  logic       load_new_a,
  input  logic [3:0] key_ms_hr,
  input  logic [3:0] key_ls_hr,
  input  logic [3:0] key_ms_min,
  input  logic [3:0] key_ls_min,
  output logic [3:0] current_time_ms_hr,
  output logic [3:0] current_time_ls_hr,
  output logic [3:0] current_time_ms_min,
  output logic [3:0] current_time_ls_min,
  output logic [3:0] alarm_time_ms_hr,
  output logic [3:0] alarm_time_ls_hr,
  output logic [3:0] alarm_time_ms_min,
  output logic [3:0] alarm_time_ls_min,
  output logic       minute_tick,
  output logic       load_err
);

  localparam int SEC_W = $clog2(SEC_PER_MIN);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_PER_MIN - 1);

  bcd_time_t        key;
  bcd_time_t        cur_q, cur_d, cur_inc;
  bcd_time_t        alm_q, alm_d;
  logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;
  logic             key_ok;
  logic             load_c_ok;
  logic             load_a_ok;
  logic             rollover;

  assign key = '{ms_hr: key_ms_hr, ls_hr: key_ls_hr, ms_min: key_ms_min, ls_min: key_ls_min};

  aclk_bcd_minute_inc u_minute_inc (
    .cur_i (cur_q),
    .nxt_o (cur_inc)
  );

  // Load arbitration: a valid current-time load swallows a coincident strobe;
  // a rejected load behaves as if no load was issued for its target.
  always_comb begin
    key_ok    = bcd_time_valid(key);
    load_c_ok = load_new_c && key_ok;
    load_a_ok = load_new_a && key_ok;
    rollover  = one_second && !load_c_ok && (sec_cnt_q == SEC_LAST);
    err_d     = (load_new_c || load_new_a) && !key_ok;
    tick_d    = rollover;

    sec_cnt_d = sec_cnt_q;
    cur_d     = cur_q;
    alm_d     = alm_q;

    if (load_c_ok) begin
      sec_cnt_d = '0;
      cur_d     = key;
    end else if (one_second) begin
      if (rollover) begin
        sec_cnt_d = '0;
        cur_d     = cur_inc;
      end else begin
        sec_cnt_d = sec_cnt_q + SEC_W'(1);
      end
    end

    if (load_a_ok) begin
      alm_d = key;
    end
  end

  // State registers; reset clears both times to 00:00 and drops the pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sec_cnt_q <= '0;
      cur_q     <= '0;
      alm_q     <= '0;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sec_cnt_q <= sec_cnt_d;
      cur_q     <= cur_d;
      alm_q     <= alm_d;
      tick_q    <= tick_d;
      err_q     <= err_d;
    end
  end

  assign current_time_ms_hr  = cur_q.ms_hr;
  assign current_time_ls_hr  = cur_q.ls_hr;
  assign current_time_ms_min = cur_q.ms_min;
  assign current_time_ls_min = cur_q.ls_min;
  assign alarm_time_ms_hr    = alm_q.ms_hr;
  assign alarm_time_ls_hr    = alm_q.ls_hr;
  assign alarm_time_ms_min   = alm_q.ms_min;
  assign alarm_time_ls_min   = alm_q.ls_min;
  assign minute_tick         = tick_q;
  assign load_err            = err_q;

endmodule

// File: tb/tb_aclk_time_keeper.sv
// Directed bench for aclk_time_keeper with a 4-strobe minute.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_aclk_time_keeper;

  logic       clk;
  logic       reset_n;
  logic       one_second;
  logic       load_new_c;
  logic       load_new_a;
  logic [3:0] key_ms_hr, key_ls_hr, key_ms_min, key_ls_min;
  logic [3:0] current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min;
  logic [3:0] alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min;
  logic       minute_tick;
  logic       load_err;

  int vectors    = 0;
  int miscompares = 0;
  int tick_cnt   = 0;

  logic [15:0] cur;
  logic [15:0] alm;
  assign cur = {current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min};
  assign alm = {alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min};

  aclk_time_keeper #(.SEC_PER_MIN(4)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .one_second          (one_second),
    .load_new_c          (load_new_c),
    .load_new_a          (load_new_a),
    .key_ms_hr           (key_ms_hr),
    .key_ls_hr           (key_ls_hr),
    .key_ms_min          (key_ms_min),
    .key_ls_min          (key_ls_min),
    .current_time_ms_hr  (current_time_ms_hr),
    .current_time_ls_hr  (current_time_ls_hr),
    .current_time_ms_min (current_time_ms_min),
    .current_time_ls_min (current_time_ls_min),
    .alarm_time_ms_hr    (alarm_time_ms_hr),
    .alarm_time_ls_hr    (alarm_time_ls_hr),
    .alarm_time_ms_min   (alarm_time_ms_min),
    .alarm_time_ls_min   (alarm_time_ls_min),
    .minute_tick         (minute_tick),
    .load_err            (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // n back-to-back strobes; counts minute_tick pulses seen after each edge
  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      one_second = 1'b1;
      cycle();
      one_second = 1'b0;
      if (minute_tick) tick_cnt++;
    end
  endtask

  task automatic set_key(input logic [15:0] k);
    {key_ms_hr, key_ls_hr, key_ms_min, key_ls_min} = k;
  endtask

  task automatic load(input logic c, input logic a, input logic [15:0] k);
    set_key(k);
    load_new_c = c;
    load_new_a = a;
    cycle();
    load_new_c = 1'b0;
    load_new_a = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    cycle();
    load(1'b1, 1'b1, 16'h0505);
    strobes(2);
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (cur !== 16'h0000) begin miscompares++; $display("FAIL reset_cur got %h want 0000", cur); end
    vectors++;
    if (alm !== 16'h0000) begin miscompares++; $display("FAIL reset_alm got %h want 0000", alm); end
    vectors++;
    if (minute_tick !== 1'b0 || load_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_pulses got tick=%b err=%b want 0 0", minute_tick, load_err);
    end
    cycle();
    reset_n = 1'b1;
    cycle();
    tick_cnt = 0;
    strobes(3);
    vectors++;
    if (cur !== 16'h0000) begin miscompares++; $display("FAIL post_reset_3s got %h want 0000", cur); end
    strobes(1);
    vectors++;
    if (cur !== 16'h0001 || tick_cnt !== 1) begin
      miscompares++; $display("FAIL post_reset_min got %h ticks=%0d want 0001 ticks=1", cur, tick_cnt);
    end
  endtask

  task automatic test_rollover();
    load(1'b1, 1'b0, 16'h0959);
    tick_cnt = 0;
    strobes(4);
    vectors++;
    if (cur !== 16'h1000 || tick_cnt !== 1) begin
      miscompares++; $display("FAIL roll_0959 got %h ticks=%0d want 1000 ticks=1", cur, tick_cnt);
    end
    load(1'b1, 1'b0, 16'h1959);
    strobes(4);
    vectors++;
    if (cur !== 16'h2000) begin miscompares++; $display("FAIL roll_1959 got %h want 2000", cur); end
    load(1'b1, 1'b0, 16'h2359);
    tick_cnt = 0;
    strobes(4);
    vectors++;
    if (cur !== 16'h0000 || tick_cnt !== 1) begin
      miscompares++; $display("FAIL roll_2359 got %h ticks=%0d want 0000 ticks=1", cur, tick_cnt);
    end
    cycle();
    vectors++;
    if (minute_tick !== 1'b0) begin miscompares++; $display("FAIL tick_width got %b want 0", minute_tick); end
  endtask

  task automatic test_alarm_load();
    load(1'b0, 1'b1, 16'h0630);
    vectors++;
    if (alm !== 16'h0630 || cur !== 16'h0000 || load_err !== 1'b0) begin
      miscompares++; $display("FAIL alarm_0630 got alm=%h cur=%h err=%b want 0630 0000 0", alm, cur, load_err);
    end
    load(1'b0, 1'b1, 16'h2400);
    vectors++;
    if (alm !== 16'h0630 || load_err !== 1'b1) begin
      miscompares++; $display("FAIL alarm_2400 got alm=%h err=%b want 0630 1", alm, load_err);
    end
    cycle();
    vectors++;
    if (load_err !== 1'b0) begin miscompares++; $display("FAIL err_width got %b want 0", load_err); end
  endtask

  task automatic test_load_current();
    // sec_cnt is 0 here; three strobes take it to 3
    tick_cnt = 0;
    strobes(3);
    set_key(16'h1234);
    load_new_c = 1'b1;
    one_second = 1'b1;
    cycle();
    load_new_c = 1'b0;
    one_second = 1'b0;
    vectors++;
    if (cur !== 16'h1234 || minute_tick !== 1'b0 || tick_cnt !== 0) begin
      miscompares++; $display("FAIL load_vs_strobe got %h tick=%b want 1234 0", cur, minute_tick);
    end
    strobes(3);
    vectors++;
    if (cur !== 16'h1234) begin miscompares++; $display("FAIL load_3s got %h want 1234", cur); end
    strobes(1);
    vectors++;
    if (cur !== 16'h1235 || tick_cnt !== 1) begin
      miscompares++; $display("FAIL load_4s got %h ticks=%0d want 1235 ticks=1", cur, tick_cnt);
    end
  endtask

  task automatic test_invalid_digits();
    load(1'b1, 1'b0, 16'h1A00);
    vectors++;
    if (cur !== 16'h1235 || load_err !== 1'b1) begin
      miscompares++; $display("FAIL key_1A00 got cur=%h err=%b want 1235 1", cur, load_err);
    end
    load(1'b1, 1'b0, 16'h1560);
    vectors++;
    if (cur !== 16'h1235 || load_err !== 1'b1) begin
      miscompares++; $display("FAIL key_1560 got cur=%h err=%b want 1235 1", cur, load_err);
    end
    load(1'b1, 1'b0, 16'h2359);
    vectors++;
    if (cur !== 16'h2359 || load_err !== 1'b0 || alm !== 16'h0630) begin
      miscompares++; $display("FAIL key_2359 got cur=%h err=%b alm=%h want 2359 0 0630", cur, load_err, alm);
    end
  endtask

  task automatic test_dual_load();
    load(1'b1, 1'b1, 16'h0745);
    vectors++;
    if (cur !== 16'h0745 || alm !== 16'h0745 || load_err !== 1'b0) begin
      miscompares++; $display("FAIL dual_0745 got cur=%h alm=%h err=%b want 0745 0745 0", cur, alm, load_err);
    end
    load(1'b1, 1'b1, 16'h3000);
    vectors++;
    if (cur !== 16'h0745 || alm !== 16'h0745 || load_err !== 1'b1) begin
      miscompares++; $display("FAIL dual_bad got cur=%h alm=%h err=%b want 0745 0745 1", cur, alm, load_err);
    end
    cycle();
    vectors++;
    if (load_err !== 1'b0) begin miscompares++; $display("FAIL dual_err_width got %b want 0", load_err); end
  endtask

  initial begin
    reset_n    = 1'b0;
    one_second = 1'b0;
    load_new_c = 1'b0;
    load_new_a = 1'b0;
    set_key(16'h0000);
    test_reset();
    test_rollover();
    test_alarm_load();
    test_load_current();
    test_invalid_digits();
    test_dual_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aclk_time_keeper.md
# aclk_time_keeper

Timekeeping stage of the alarm clock. It keeps the running current time as four BCD digits (HH:MM). It advances that time from a one-second strobe and holds the alarm-time register. It loads either value from the keypad digit register on command. Its outputs drive the `current_time_*` and `alarm_time_*` inputs of `aclk_lcd_display`.

## Interface
Parameters:
- `SEC_PER_MIN`, default 60: one_second strobes per minute. Range 2..255; shortened in simulation.

Ports:
- `clk`  in  1: system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `one_second`  in  1: single-cycle strobe, one per second.
- `load_new_c`  in  1: single-cycle command; load the key time into current time.
- `load_new_a`  in  1: single-cycle command; load the key time into the alarm register.
- `key_ms_hr`, `key_ls_hr`, `key_ms_min`, `key_ls_min`  in  4 each: keypad BCD digits.
- `current_time_ms_hr`, `current_time_ls_hr`, `current_time_ms_min`, `current_time_ls_min`  out  4 each: registered current time.
- `alarm_time_ms_hr`, `alarm_time_ls_hr`, `alarm_time_ms_min`, `alarm_time_ls_min`  out  4 each: registered alarm time.
- `minute_tick`  out  1: one-cycle pulse on each minute rollover.
- `load_err`  out  1: one-cycle pulse when a load was rejected.

## Operation
- Reset (`reset_n`=0, asynchronous):
  - All time digits and all alarm digits are 0 (00:00).
  - The seconds counter is 0.
  - `minute_tick`=0 and `load_err`=0.
- Seconds counter, `sec_cnt`, is ceil(log2(SEC_PER_MIN)) bits wide:
  - Each `one_second` increments it.
  - At SEC_PER_MIN-1 it wraps to 0, advances the time by one minute, and pulses `minute_tick`.
- Minute advance is a BCD cascade:
  - ls_min 0..9 carries into ms_min 0..5.
  - ms_min carries into the hour.
  - Hours count 00..23; 23:59 wraps to 00:00.
  - 09:59 → 10:00; 19:59 → 20:00.
- Key validity: the key value is valid only when all of these hold:
  - key_ms_hr ≤2.
  - key_ls_hr ≤9, and ≤3 when key_ms_hr=2.
  - key_ms_min ≤5.
  - key_ls_min ≤9.
- `load_new_c` with a valid key:
  - Current time takes the key value.
  - `sec_cnt` clears to 0.
  - No `minute_tick` that cycle.
- `load_new_a` with a valid key: the alarm register takes the key value. Current time is unaffected.
- Invalid key on either load: the target register is unchanged and `load_err` pulses.
- Simultaneous events:
  - `load_new_c` together with `one_second`: the load wins; the strobe is discarded and `sec_cnt`=0.
  - `load_new_c` together with `load_new_a`: both registers load the same key value. An invalid key gives a single `load_err` pulse.
  - `load_new_a` together with a rollover: both take effect.
- Undefined digits (>9) never propagate into the registers.

## Timing
- Every output is registered; there is no combinational input-to-output path.
- Load latency is 1 cycle: a command sampled at edge N appears on the outputs after edge N.
- The rollover and its `minute_tick` appear in the same cycle, 1 cycle after the final `one_second`.
- `load_err` rises 1 cycle after the offending command and lasts exactly 1 cycle.
- Strobes are assumed level-clean single-cycle pulses. A strobe held high for k cycles counts k times.
- Reset mid-count abandons the count immediately. The first `one_second` after reset release makes `sec_cnt`=1.

## Structure
- Shared package `aclk_pkg` holds:
  - Constants: `HR_MS_MAX`=2, `HR_LS_MAX_AT_2`=3, `MIN_MS_MAX`=5, `DIGIT_MAX`=9.
  - The BCD-time typedef: a struct of 4 × 4-bit digits.
  - Function `bcd_time_valid`, shared with the keypad stage.
- One sub-module, `aclk_bcd_minute_inc`: combinational next-minute logic on a BCD time, with wrap at 23:59.
- The top level contains the seconds counter, load arbitration and both registers.

## Test plan
- Reset mid-run, then release:
  - All outputs are 00:00 and `minute_tick`=0 while reset is asserted.
  - After SEC_PER_MIN=4 strobes, current time is 00:01 with one `minute_tick`.
- Rollover sequence:
  - Load 09:59, then give 4 strobes → 10:00.
  - Load 23:59, then give 4 strobes → 00:00 and `minute_tick` pulses once.
- Alarm load:
  - Key 06:30 with `load_new_a` → alarm is 06:30 one cycle later; current time is unchanged.
  - Key 24:00 with `load_new_a` → alarm stays 06:30 and `load_err` pulses 1 cycle.
- Current-time load:
  - Key 12:34 with `load_new_c` issued in the same cycle as `one_second`, while `sec_cnt`=3 → time is 12:34 and there is no tick.
  - 4 further strobes are needed to reach 12:35.
- Invalid digits:
  - Key 1A:00 with `load_new_c` → rejected with `load_err`.
  - Key 15:60 → rejected.
  - Key 23:59 → accepted.
- Dual load: `load_new_c`, `load_new_a` and key 07:45 in one cycle → current time and alarm both read 07:45, and `load_err`=0.
